rf_exec_seq: RTL

RF_EXEC_SEQ -- requirements
Module: rf_exec_seq

---
 rtl/rf_exec_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rf_exec_seq.sv
// Single-issue execute sequencer: reads two registers, runs one ALU op
// and writes the result back through an external register file.
module rf_exec_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              done,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_c
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t state, state_nxt;
  logic accept;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;

  logic [DATA_W-1:0] a, b, res;
  logic [DATA_W:0]   sum;
  logic              carry;
  logic [2:0]        shamt;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = WB;
      WB:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready      = (state == IDLE);
  assign busy          = (state != IDLE);
  assign rf_we         = (state == WB);
  assign rf_write_addr = rd_q;
  assign rf_read_addr1 = rs1_q;
  assign rf_read_addr2 = rs2_q;

  assign a     = rf_read_data1;
  assign b     = rf_read_data2;
  assign shamt = b[2:0];
  assign sum   = {1'b0, a} + {1'b0, b};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    unique case (op_q)
      3'b000: begin
        res   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      3'b001: begin
        res   = a - b;
        carry = (a < b);
      end
      3'b010: res = a & b;
      3'b011: res = a | b;
      3'b100: res = a ^ b;
      3'b101: res = a << shamt;
      3'b110: res = a >> shamt;
      3'b111: res = a;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rf_write_data <= '0;
      flag_z        <= 1'b0;
      flag_c        <= 1'b0;
      done          <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == WB);
      if (accept) begin
        op_q  <= in_op;
        rd_q  <= in_rd;
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
      end
      // Result and flags are frozen here so WB drives stable values.
      if (state == EXEC) begin
        rf_write_data <= res;
        flag_z        <= (res == '0);
        flag_c        <= carry;
      end
    end
  end

endmodule
